ascii_cmd_parser: RTL and testbench
===================================

// Module: ascii_cmd_parser
// PURPOSE
//  Receive-side parser that turns ASCII command frames from the UART RX byte stream into packed-BCD
//  time, date and weekday load requests for the clock core. It is the inverse of the BCD-to-ASCII
//  path used for display and transmit.
//  Frames: 'T'+HHMMSS+term, 'D'+YYYYMMDD+term, 'W'+d+term. term = CR (0x0D) or LF (0x0A).
// PARAMETERS
//  TIMEOUT_CYC  100_000_000  max clk cycles between bytes inside a frame before abort (>=2)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset_p       in   1   asynchronous reset, active-high
//  rx_data       in   8   received byte; valid only while rx_valid=1
//  rx_valid      in   1   1-cycle strobe, one per received byte
//  time_bcd      out  24  {H1,H0,M1,M0,S1,S0} BCD of the last accepted 'T' frame
//  time_load     out  1   1-cycle pulse: time_bcd updated
//  date_bcd      out  32  {Y3,Y2,Y1,Y0,Mo1,Mo0,D1,D0} BCD of the last accepted 'D' frame
//  date_load     out  1   1-cycle pulse: date_bcd updated
//  weekday       out  4   0=SUN..6=SAT from the last accepted 'W' frame
//  weekday_load  out  1   1-cycle pulse: weekday updated
//  busy          out  1   1 while a frame is in progress (state != IDLE)
//  err           out  1   1-cycle pulse: frame aborted
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; every output 0; shift register, digit count and timer cleared.
//  - All outputs are registered. Bytes are consumed only in cycles with rx_valid=1.
//  - FSM states:
//    IDLE:  'T' -> DIGITS (need=6); 'D' -> DIGITS (need=8); 'W' -> DIGITS (need=1).
//           Any other byte, including CR/LF, is silently ignored (no err).
//    DIGITS: byte in '0'..'9' -> nibble = rx_data-8'h30, sh <= {sh[27:0], nibble}, cnt++.
//           When cnt reaches need -> TERM. Any non-digit -> ABORT.
//    TERM:  CR or LF -> range check. On pass: load the target register and pulse its *_load.
//           On fail -> ABORT. Any other byte -> ABORT.
//    ABORT: not a holding state. Assert err for one cycle, go to IDLE.
//           The offending byte is discarded; it is not reinterpreted as a header.
//  - Latency: the *_load pulse and the register update occur in the cycle after the clock edge
//    that samples the terminator. Load registers and err are never asserted in the same cycle.
//  - Range checks (BCD compare):
//    T: HH<=0x23, MM<=0x59, SS<=0x59.
//    D: month 0x01..0x12, day 0x01..0x31 (no per-month limit); year unchecked.
//    W: digit<=6.
//  - Width rules:
//    T: time_bcd = sh[23:0].
//    D: date_bcd = sh[31:0].
//    W: weekday = sh[3:0].
//    Unused upper shift bits are ignored. cnt is 4 bits.
//  - Timeout: a counter runs while state != IDLE and is cleared on every rx_valid.
//    If it reaches TIMEOUT_CYC-1 with no byte -> ABORT.
//    If rx_valid arrives in the same cycle as the expiry, the byte wins and the counter is cleared.
//  - Failed or aborted frames leave time_bcd, date_bcd and weekday unchanged.
//  - Back-to-back frames: a header byte may arrive the cycle after a terminator. It is accepted
//    while the *_load pulse is high.
//  - busy=1 from the cycle after the header byte until the cycle the state returns to IDLE.
// TESTING
//  1. "T123045\r" -> one cycle after CR: time_bcd=24'h123045, time_load=1 for 1 cycle; err stays 0.
//  2. "D20240817\n" -> date_bcd=32'h20240817 with date_load pulse.
//     Then "W6\r" -> weekday=4'd6 with weekday_load pulse.
//  3. "T246000\r" -> err pulse after CR; time_bcd keeps its previous value; no time_load.
//     Repeat with "D20241301\r" (month 13) and "W7\r": each gives err only.
//  4. "T12A" -> err pulse the cycle after 'A'; busy=0.
//     Then "T000000\r" -> time_bcd=0, time_load=1.
//  5. With TIMEOUT_CYC=16: send "T12", then idle 16 cycles -> err pulse, busy=0.
//     Then a stray "\r\n" -> no err and no load.
//  6. Assert reset_p mid-frame after "D2024", then send "0817\r" -> nothing loads, no err.
//     Then a full "D20240817\r" -> accepted.

Source files
------------

// File: rtl/ascii_cmd_parser.sv
// ascii_cmd_parser
//   Receive-side parser turning ASCII command frames from the UART RX byte
//   stream into packed-BCD load requests for the clock core.
//   Frames: 'T'+HHMMSS+term, 'D'+YYYYMMDD+term, 'W'+d+term; term = CR or LF.
// Ports
//   clk, reset_p             clock (rising edge), async active-high reset
//   rx_data, rx_valid        received byte and its 1-cycle strobe
//   time_bcd, time_load      {H1,H0,M1,M0,S1,S0} and its update pulse
//   date_bcd, date_load      {Y3..Y0,Mo1,Mo0,D1,D0} and its update pulse
//   weekday, weekday_load    0=SUN..6=SAT and its update pulse
//   busy                     frame in progress
//   err                      1-cycle pulse when a frame is aborted
module ascii_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] time_bcd,
  output logic        time_load,
  output logic [31:0] date_bcd,
  output logic        date_load,
  output logic [3:0]  weekday,
  output logic        weekday_load,
  output logic        busy,
  output logic        err
);

  localparam int unsigned   TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_TERM, S_ABORT} state_e;
  typedef enum logic [1:0] {K_TIME, K_DATE, K_WDAY} kind_e;

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [31:0]   sh_q, sh_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    need_q, need_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [23:0] time_bcd_q, time_bcd_d;
  logic [31:0] date_bcd_q, date_bcd_d;
  logic [3:0]  weekday_q, weekday_d;
  logic        time_load_q, time_load_d;
  logic        date_load_q, date_load_d;
  logic        weekday_load_q, weekday_load_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [7:0] dig_off;
  logic       is_digit, is_term, range_ok, expired, accept;

  // Byte classification and range check of the collected digits
  always_comb begin
    // Unsigned wrap makes a single compare cover both ends of '0'..'9'
    dig_off  = rx_data - 8'h30;
    is_digit = dig_off < 8'd10;
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    expired  = !rx_valid && (tmr_q == TMAX);
    range_ok = 1'b0;
    case (kind_q)
      K_TIME:  range_ok = (sh_q[23:16] <= 8'h23) && (sh_q[15:8] <= 8'h59) &&
                          (sh_q[7:0] <= 8'h59);
      K_DATE:  range_ok = (sh_q[15:8] >= 8'h01) && (sh_q[15:8] <= 8'h12) &&
                          (sh_q[7:0] >= 8'h01) && (sh_q[7:0] <= 8'h31);
      K_WDAY:  range_ok = sh_q[3:0] <= 4'd6;
      default: range_ok = 1'b0;
    endcase
    accept = (state_q == S_TERM) && rx_valid && is_term && range_ok;
  end

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q        <= S_IDLE;
      kind_q         <= K_TIME;
      sh_q           <= '0;
      cnt_q          <= '0;
      need_q         <= '0;
      tmr_q          <= '0;
      time_bcd_q     <= '0;
      date_bcd_q     <= '0;
      weekday_q      <= '0;
      time_load_q    <= 1'b0;
      date_load_q    <= 1'b0;
      weekday_load_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      sh_q           <= sh_d;
      cnt_q          <= cnt_d;
      need_q         <= need_d;
      tmr_q          <= tmr_d;
      time_bcd_q     <= time_bcd_d;
      date_bcd_q     <= date_bcd_d;
      weekday_q      <= weekday_d;
      time_load_q    <= time_load_d;
      date_load_q    <= date_load_d;
      weekday_load_q <= weekday_load_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    need_d  = need_q;
    tmr_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h54:   begin state_d = S_DIGITS; kind_d = K_TIME; need_d = 4'd6; end
            8'h44:   begin state_d = S_DIGITS; kind_d = K_DATE; need_d = 4'd8; end
            8'h57:   begin state_d = S_DIGITS; kind_d = K_WDAY; need_d = 4'd1; end
            default: ;
          endcase
          sh_d  = '0;
          cnt_d = '0;
        end
      end
      S_DIGITS: begin
        if (rx_valid) begin
          if (is_digit) begin
            sh_d  = {sh_q[27:0], dig_off[3:0]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == need_q) state_d = S_TERM;
          end else begin
            state_d = S_ABORT;
          end
        end else if (expired) begin
          state_d = S_ABORT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_TERM: begin
        if (rx_valid) begin
          state_d = accept ? S_IDLE : S_ABORT;
        end else if (expired) begin
          state_d = S_ABORT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: every output is registered from its _d value
  always_comb begin
    time_bcd_d     = time_bcd_q;
    date_bcd_d     = date_bcd_q;
    weekday_d      = weekday_q;
    time_load_d    = 1'b0;
    date_load_d    = 1'b0;
    weekday_load_d = 1'b0;
    busy_d         = (state_d != S_IDLE);
    err_d          = (state_d == S_ABORT);
    if (accept) begin
      case (kind_q)
        K_TIME:  begin time_bcd_d = sh_q[23:0]; time_load_d    = 1'b1; end
        K_DATE:  begin date_bcd_d = sh_q;       date_load_d    = 1'b1; end
        K_WDAY:  begin weekday_d  = sh_q[3:0];  weekday_load_d = 1'b1; end
        default: ;
      endcase
    end
  end

  assign time_bcd     = time_bcd_q;
  assign time_load    = time_load_q;
  assign date_bcd     = date_bcd_q;
  assign date_load    = date_load_q;
  assign weekday      = weekday_q;
  assign weekday_load = weekday_load_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ascii_cmd_parser.sv
module tb_ascii_cmd_parser;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [23:0] time_bcd;
  logic        time_load;
  logic [31:0] date_bcd;
  logic        date_load;
  logic [3:0]  weekday;
  logic        weekday_load;
  logic        busy;
  logic        err;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned err_cnt = 0, tl_cnt = 0, dl_cnt = 0, wl_cnt = 0;
  int unsigned e0, t0, d0, w0;

  ascii_cmd_parser #(.TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .time_bcd     (time_bcd),
    .time_load    (time_load),
    .date_bcd     (date_bcd),
    .date_load    (date_load),
    .weekday      (weekday),
    .weekday_load (weekday_load),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (err)          err_cnt++;
    if (time_load)    tl_cnt++;
    if (date_load)    dl_cnt++;
    if (weekday_load) wl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  // Sends bytes back to back; returns just after the edge sampling the last one
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    e0 = err_cnt; t0 = tl_cnt; d0 = dl_cnt; w0 = wl_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_p  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    idle(1);
    check("rst_time", time_bcd, 0);
    check("rst_date", date_bcd, 0);
    check("rst_wday", weekday, 0);
    check("rst_flags", {busy, err, time_load, date_load, weekday_load}, 0);

    // 1: basic time frame
    snap();
    send_str("T123045\015");
    check("t1_load", time_load, 1);
    check("t1_time", time_bcd, 32'h123045);
    check("t1_busy", busy, 0);
    idle(1);
    check("t1_load_off", time_load, 0);
    check("t1_noerr", err_cnt - e0, 0);
    check("t1_pulses", tl_cnt - t0, 1);

    // 2: date and weekday
    send_str("D20240817\n");
    check("t2_dload", date_load, 1);
    check("t2_date", date_bcd, 32'h20240817);
    idle(1);
    check("t2_dload_off", date_load, 0);
    send_str("W6\015");
    check("t2_wload", weekday_load, 1);
    check("t2_wday", weekday, 6);
    idle(1);

    // Byte arriving exactly at timeout expiry still counts; max legal time
    send_str("T2");
    idle(15);
    send_str("35959\015");
    check("exp_byte_wins", time_bcd, 32'h235959);
    check("exp_load", time_load, 1);
    idle(1);

    // 3: range failures
    snap();
    send_str("T246000\015");
    check("t3_err", err, 1);
    check("t3_noload", time_load, 0);
    idle(1);
    check("t3_err_off", err, 0);
    check("t3_time_keep", time_bcd, 32'h235959);
    send_str("D20241301\015");
    check("t3d_err", err, 1);
    idle(1);
    check("t3d_date_keep", date_bcd, 32'h20240817);
    send_str("D20241200\015");
    check("t3d0_err", err, 1);
    idle(1);
    send_str("W7\015");
    check("t3w_err", err, 1);
    idle(1);
    check("t3w_wday_keep", weekday, 6);
    check("t3_err_pulses", err_cnt - e0, 4);
    check("t3_no_loads", (tl_cnt - t0) + (dl_cnt - d0) + (wl_cnt - w0), 0);
    send_str("D99991231\015");
    check("date_max", date_bcd, 32'h99991231);
    idle(1);

    // 4: non-digit abort, then recovery
    send_str("T12");
    check("t4_busy", busy, 1);
    send_str("A");
    check("t4_err", err, 1);
    idle(1);
    check("t4_err_off", err, 0);
    check("t4_busy_off", busy, 0);
    send_str("T000000\015");
    check("t4_load", time_load, 1);
    check("t4_time", time_bcd, 0);
    idle(1);

    // Back-to-back frames: header during the load pulse
    send_str("T010203\015");
    check("b2b_tload", time_load, 1);
    check("b2b_time", time_bcd, 32'h010203);
    send_str("W0\015");
    check("b2b_wload", weekday_load, 1);
    check("b2b_wday", weekday, 0);
    idle(1);

    // 5: inter-byte timeout
    send_str("T12");
    idle(15);
    check("t5_no_err_yet", err, 0);
    idle(1);
    check("t5_err", err, 1);
    idle(1);
    check("t5_busy_off", busy, 0);
    snap();
    send_str("\015\n");
    idle(2);
    check("t5_stray_err", err_cnt - e0, 0);
    check("t5_stray_load", (tl_cnt - t0) + (dl_cnt - d0) + (wl_cnt - w0), 0);

    // 6: reset mid-frame
    send_str("D2024");
    @(negedge clk);
    rx_valid = 1'b0;
    reset_p  = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    #1;
    check("t6_rst_date", date_bcd, 0);
    check("t6_rst_busy", busy, 0);
    snap();
    send_str("0817\015");
    idle(2);
    check("t6_no_err", err_cnt - e0, 0);
    check("t6_no_load", (tl_cnt - t0) + (dl_cnt - d0) + (wl_cnt - w0), 0);
    check("t6_date_zero", date_bcd, 0);
    send_str("D20240817\015");
    check("t6_dload", date_load, 1);
    check("t6_date", date_bcd, 32'h20240817);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
